// File: rtl/tlul_reg_responder.sv
// tlul_reg_responder: TL-UL device endpoint turning one A/D transaction at a time into a req/ack register access.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   tl_i / tl_o         TL-UL A channel + d_ready in, D channel + a_ready out
//   req_o, we_o         register access request (held until ack_i), write flag
//   addr_o, wdata_o     word-aligned byte address, write data
//   be_o                byte enables from a_mask
//   ack_i, rdata_i      access complete, read data (valid with ack_i)
//   err_i               register-side error (valid with ack_i)
package tlul_pkg;
    localparam logic [2:0] PutFullData    = 3'h0;
    localparam logic [2:0] PutPartialData = 3'h1;
    localparam logic [2:0] Get            = 3'h4;
    localparam logic [2:0] AccessAck      = 3'h0;
    localparam logic [2:0] AccessAckData  = 3'h1;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tlul_h2d_t;
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic [3:0]  d_user;
        logic        d_error;
        logic        a_ready;
    } tlul_d2h_t;
endpackage

module tlul_reg_responder #(
    parameter int RegAw         = 8,
    parameter int TimeoutCycles = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  tlul_pkg::tlul_h2d_t   tl_i,
    output tlul_pkg::tlul_d2h_t   tl_o,
    output logic                  req_o,
    output logic                  we_o,
    output logic [RegAw-1:0]      addr_o,
    output logic [31:0]           wdata_o,
    output logic [3:0]            be_o,
    input  logic                  ack_i,
    input  logic [31:0]           rdata_i,
    input  logic                  err_i
);
    import tlul_pkg::*;

    // One-hot so a_ready, req_o and d_valid are each a single state flop.
    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        ACCESS = 3'b010,
        RESP   = 3'b100
    } state_e;

    localparam logic [15:0] TimeoutLimit = 16'(TimeoutCycles);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [RegAw-1:0]  addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [1:0]        size_q, size_d;
    logic [7:0]        source_q, source_d;
    logic [2:0]        dop_q, dop_d;
    logic              err_q, err_d;
    logic [31:0]       data_q, data_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              is_get, is_put, aligned, illegal;
    logic [3:0]        lanes;
    logic              unused_tl;

    assign unused_tl = ^{tl_i.a_param, tl_i.a_address[31:RegAw]};

    assign is_get  = tl_i.a_opcode == Get;
    assign is_put  = tl_i.a_opcode == PutFullData || tl_i.a_opcode == PutPartialData;
    assign lanes   = tl_i.a_size == 2'd0 ? 4'b0001 << tl_i.a_address[1:0] :
                     tl_i.a_size == 2'd1 ? 4'b0011 << tl_i.a_address[1:0] : 4'b1111;
    assign aligned = tl_i.a_size == 2'd0 ||
                     (tl_i.a_size == 2'd1 && !tl_i.a_address[0]) ||
                     (tl_i.a_size == 2'd2 && tl_i.a_address[1:0] == 2'b00);
    assign illegal = !(is_get || is_put) || tl_i.a_size > 2'd2 || !aligned ||
                     (tl_i.a_mask & ~lanes) != 4'b0000 ||
                     (tl_i.a_opcode == PutFullData && tl_i.a_mask != lanes) ||
                     tl_i.a_mask == 4'b0000;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        size_d   = size_q;
        source_d = source_q;
        dop_d    = dop_q;
        err_d    = err_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (tl_i.a_valid) begin
                    we_d     = is_put;
                    addr_d   = {tl_i.a_address[RegAw-1:2], 2'b00};
                    wdata_d  = tl_i.a_data;
                    be_d     = tl_i.a_mask;
                    size_d   = tl_i.a_size;
                    source_d = tl_i.a_source;
                    // Anything that is not a Put answers with data, so bad opcodes read as all-ones.
                    dop_d    = is_put ? AccessAck : AccessAckData;
                    err_d    = illegal;
                    data_d   = (illegal && !is_put) ? '1 : '0;
                    cnt_d    = '0;
                    state_d  = illegal ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 16'd1;
                // An ack in the final allowed cycle still wins over the timeout.
                if (ack_i) begin
                    err_d   = err_i;
                    data_d  = we_q ? '0 : (err_i ? '1 : rdata_i);
                    state_d = RESP;
                end else if (cnt_q + 16'd1 == TimeoutLimit) begin
                    err_d   = 1'b1;
                    data_d  = we_q ? '0 : '1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (tl_i.d_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            size_q   <= '0;
            source_q <= '0;
            dop_q    <= '0;
            err_q    <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            size_q   <= size_d;
            source_q <= source_d;
            dop_q    <= dop_d;
            err_q    <= err_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_o   = state_q[1];
    assign we_o    = we_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;
    assign be_o    = be_q;

    assign tl_o.a_ready  = state_q[0];
    assign tl_o.d_valid  = state_q[2];
    assign tl_o.d_opcode = dop_q;
    assign tl_o.d_param  = 3'b000;
    assign tl_o.d_size   = size_q;
    assign tl_o.d_source = source_q;
    assign tl_o.d_sink   = 1'b0;
    assign tl_o.d_data   = data_q;
    assign tl_o.d_user   = 4'b0000;
    assign tl_o.d_error  = err_q;
endmodule

// File: tb/tb_tlul_reg_responder.sv
// tb_tlul_reg_responder: directed table plus randomized transactions against a spec-level model.
module tb_tlul_reg_responder;
    localparam int TO = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    tlul_pkg::tlul_h2d_t tl_i;
    tlul_pkg::tlul_d2h_t tl_o;
    logic        req_o, we_o, ack_i, err_i;
    logic [7:0]  addr_o;
    logic [31:0] wdata_o, rdata_i;
    logic [3:0]  be_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    tlul_reg_responder #(.RegAw(8), .TimeoutCycles(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .tl_i(tl_i), .tl_o(tl_o),
        .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
        .ack_i(ack_i), .rdata_i(rdata_i), .err_i(err_i)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [7:0]  src;
        int          w;
        logic [31:0] rdata;
        logic        err;
        int          bp;
        bit          pend;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        logic [2:0]  exp_dop;
    } vec_t;

    vec_t tbl[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(logic [2:0] op, logic [31:0] addr, logic [1:0] size, logic [3:0] mask,
                                logic [31:0] data, logic [7:0] src, int w, logic [31:0] rdata, logic err,
                                int bp, bit pend, logic exp_err, logic [31:0] exp_data, int exp_lat,
                                logic [2:0] exp_dop);
        vec_t v;
        v.op = op; v.addr = addr; v.size = size; v.mask = mask; v.data = data; v.src = src;
        v.w = w; v.rdata = rdata; v.err = err; v.bp = bp; v.pend = pend;
        v.exp_err = exp_err; v.exp_data = exp_data; v.exp_lat = exp_lat; v.exp_dop = exp_dop;
        return v;
    endfunction

    // Byte lanes touched by a 2^size-byte access starting at byte offset addr%4.
    function automatic logic [3:0] lanes_of(logic [31:0] addr, logic [1:0] size);
        logic [3:0] l = '0;
        int off = int'(addr % 4);
        int nb = 1 << size;
        for (int b = 0; b < 4; b++) l[b] = (b >= off && b < off + nb);
        return l;
    endfunction

    function automatic bit model_legal(vec_t v);
        logic [3:0] l;
        if (!(v.op == 3'd0 || v.op == 3'd1 || v.op == 3'd4)) return 0;
        if (v.size > 2) return 0;
        if (v.addr % (32'd1 << v.size) != 0) return 0;
        if (v.mask == 4'd0) return 0;
        l = lanes_of(v.addr, v.size);
        for (int b = 0; b < 4; b++) begin
            if (v.mask[b] && !l[b]) return 0;
            if (v.op == 3'd0 && !v.mask[b] && l[b]) return 0;
        end
        return 1;
    endfunction

    function automatic vec_t model(vec_t v);
        bit legal = model_legal(v);
        bit put = (v.op == 3'd0 || v.op == 3'd1);
        bit tmo = legal && v.w >= TO;
        v.exp_err  = !legal || tmo || v.err;
        v.exp_data = put ? 32'd0 : (v.exp_err ? 32'hFFFF_FFFF : v.rdata);
        v.exp_lat  = !legal ? 1 : (tmo ? TO + 1 : v.w + 2);
        v.exp_dop  = put ? 3'd0 : 3'd1;
        return v;
    endfunction

    task automatic drive_a(vec_t v);
        tl_i.a_valid   = 1'b1;
        tl_i.a_opcode  = v.op;
        tl_i.a_param   = 3'd0;
        tl_i.a_size    = v.size;
        tl_i.a_source  = v.src;
        tl_i.a_address = v.addr;
        tl_i.a_mask    = v.mask;
        tl_i.a_data    = v.data;
    endtask

    task automatic check_d(vec_t v);
        chk("d_valid", tl_o.d_valid, 1);
        chk("a_ready_resp", tl_o.a_ready, 0);
        chk("req_o_resp", req_o, 0);
        chk("d_opcode", tl_o.d_opcode, v.exp_dop);
        chk("d_size", tl_o.d_size, v.size);
        chk("d_source", tl_o.d_source, v.src);
        chk("d_param_sink_user", {tl_o.d_param, tl_o.d_sink, tl_o.d_user}, 0);
        chk("d_error", tl_o.d_error, v.exp_err);
        chk("d_data", tl_o.d_data, v.exp_data);
    endtask

    task automatic run(vec_t v, vec_t nx, bit now);
        int waited = 0;
        bit legal, put, tmo;
        legal = v.exp_lat > 1;
        put = (v.op == 3'd0 || v.op == 3'd1);
        tmo = legal && v.w >= TO;
        drive_a(v);
        while (!tl_o.a_ready && waited < 20) begin
            @(posedge clk_i); #1;
            waited++;
        end
        if (!tl_o.a_ready) begin
            chk("a_ready_wait", tl_o.a_ready, 1);
            tl_i.a_valid = 1'b0;
            return;
        end
        if (now) chk("accept_after_handshake", waited, 0);
        @(posedge clk_i); #1;
        tl_i.a_valid = 1'b0;
        for (int e = 1; e < v.exp_lat; e++) begin
            chk("d_valid_early", tl_o.d_valid, 0);
            chk("a_ready_busy", tl_o.a_ready, 0);
            chk("req_o", req_o, 1);
            chk("we_o", we_o, put);
            chk("addr_o", addr_o, {v.addr[7:2], 2'b00});
            chk("be_o", be_o, v.mask);
            chk("wdata_o", wdata_o, v.data);
            if (!tmo && e == v.w + 1) begin
                ack_i = 1'b1; rdata_i = v.rdata; err_i = v.err;
            end
            @(posedge clk_i); #1;
            ack_i = 1'b0; rdata_i = $urandom; err_i = 1'($urandom);
        end
        if (!legal) chk("req_o_illegal", req_o, 0);
        if (tmo) ack_i = 1'b1;
        if (v.pend) drive_a(nx);
        for (int i = 0; i <= v.bp; i++) begin
            check_d(v);
            if (i < v.bp) begin
                @(posedge clk_i); #1;
            end
        end
        tl_i.d_ready = 1'b1;
        @(posedge clk_i); #1;
        tl_i.d_ready = 1'b0;
        chk("d_valid_after_hs", tl_o.d_valid, 0);
        chk("a_ready_after_hs", tl_o.a_ready, 1);
        if (tmo) begin
            @(posedge clk_i); #1;
            chk("late_ack_no_resp", tl_o.d_valid, 0);
            chk("late_ack_no_req", req_o, 0);
            ack_i = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, nx;
        int r;
        tl_i = '0; ack_i = 1'b0; err_i = 1'b0; rdata_i = '0; rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_a_ready", tl_o.a_ready, 1);
        chk("rst_d_valid", tl_o.d_valid, 0);
        chk("rst_req", req_o, 0);
        chk("rst_we_addr_be", {we_o, addr_o, be_o}, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_d_fields", {tl_o.d_opcode, tl_o.d_size, tl_o.d_source, tl_o.d_error}, 0);
        chk("rst_d_data", tl_o.d_data, 0);
        rst_i = 1'b0;

        tbl.push_back(mk(3'd4, 32'h10, 2, 4'hF, 32'h0, 8'd5, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 32'hCAFE_F00D, 2, 1));
        tbl.push_back(mk(3'd1, 32'h06, 1, 4'hC, 32'hABCD_0000, 8'd2, 3, 32'h0, 0, 1, 0, 0, 32'h0, 5, 0));
        tbl.push_back(mk(3'd3, 32'h00, 2, 4'hF, 32'h0, 8'd7, 0, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 1));
        tbl.push_back(mk(3'd4, 32'h02, 2, 4'hF, 32'h0, 8'd8, 0, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 1));
        tbl.push_back(mk(3'd4, 32'h0C, 2, 4'hF, 32'h0, 8'd9, TO, 32'h1234_5678, 0, 2, 0, 1, 32'hFFFF_FFFF, TO + 1, 1));
        tbl.push_back(mk(3'd0, 32'h00, 2, 4'h7, 32'h1122_3344, 8'd1, 0, 32'h0, 0, 0, 0, 1, 32'h0, 1, 0));
        tbl.push_back(mk(3'd0, 32'h21, 0, 4'h2, 32'h0000_AA00, 8'd3, 1, 32'h0, 0, 0, 0, 0, 32'h0, 3, 0));
        tbl.push_back(mk(3'd4, 32'h03, 0, 4'h1, 32'h0, 8'd10, 0, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 1));
        tbl.push_back(mk(3'd4, 32'h00, 2, 4'h0, 32'h0, 8'd11, 0, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 1));
        tbl.push_back(mk(3'd4, 32'h00, 3, 4'hF, 32'h0, 8'd12, 0, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 1));
        tbl.push_back(mk(3'd4, 32'h40, 2, 4'hF, 32'h0, 8'd4, 2, 32'h5A5A_5A5A, 1, 1, 0, 1, 32'hFFFF_FFFF, 4, 1));
        tbl.push_back(mk(3'd4, 32'h80, 2, 4'hF, 32'h0, 8'd6, 1, 32'h0BAD_BEEF, 0, 10, 1, 0, 32'h0BAD_BEEF, 3, 1));
        tbl.push_back(mk(3'd1, 32'h22, 1, 4'h4, 32'h0055_0000, 8'd7, 0, 32'h0, 0, 0, 0, 0, 32'h0, 2, 0));
        tbl.push_back(mk(3'd1, 32'hFC, 2, 4'h5, 32'hDEAD_BEEF, 8'hFF, 2, 32'h0, 1, 0, 0, 1, 32'h0, 4, 0));
        tbl.push_back(mk(3'd4, 32'h01, 0, 4'h2, 32'h0, 8'd13, 3, 32'h0000_3300, 0, 0, 0, 0, 32'h0000_3300, 5, 1));

        for (int i = 0; i < tbl.size(); i++)
            run(tbl[i], (i + 1 < tbl.size()) ? tbl[i + 1] : tbl[i], i > 0 && tbl[i - 1].pend);

        // Reset in the middle of an access: no response may follow.
        v = mk(3'd4, 32'h30, 2, 4'hF, 32'h0, 8'd21, TO, 32'h0, 0, 0, 0, 0, 32'h0, 0, 1);
        drive_a(v);
        @(posedge clk_i); #1;
        tl_i.a_valid = 1'b0;
        chk("pre_rst_req", req_o, 1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("midrst_req", req_o, 0);
        chk("midrst_d_valid", tl_o.d_valid, 0);
        chk("midrst_a_ready", tl_o.a_ready, 1);
        ack_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_i); #1;
            ack_i = 1'b0;
            chk("midrst_no_resp", tl_o.d_valid, 0);
        end

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            v.op   = r < 3 ? 3'd4 : r < 5 ? 3'd0 : r < 7 ? 3'd1 : 3'($urandom_range(0, 7));
            v.size = 2'($urandom_range(0, 3));
            v.addr = $urandom;
            v.mask = $urandom_range(0, 1) ? lanes_of(v.addr, v.size) : 4'($urandom);
            v.data = $urandom;
            v.src  = 8'($urandom);
            v.w    = $urandom_range(0, TO);
            v.rdata = $urandom;
            v.err  = $urandom_range(0, 3) == 0;
            v.bp   = $urandom_range(0, 3);
            v.pend = 0;
            v = model(v);
            nx = v;
            run(v, nx, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
